// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetcher.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } if_state_e;

    localparam int          IF_DEPTH_DEFAULT = 4;
    localparam logic [31:0] FETCH_INC        = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Shift-style prefetch queue with flush; head sits in entry 0 and is zero when empty.
// Push is visible at the head one cycle later; push is ignored when full without a pop.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic          head_valid,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  ent   [DEPTH];
    logic [W-1:0]  ent_n [DEPTH];
    logic [CW-1:0] cnt_mid;
    logic [CW-1:0] cnt_n;

    // Vacated slots are cleared so the head reads zero whenever the queue is empty.
    always_comb begin
        ent_n   = ent;
        cnt_mid = count;
        if (pop && count != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_n[i] = ent[i+1];
            ent_n[DEPTH-1] = '0;
            cnt_mid = count - CW'(1);
        end
        cnt_n = cnt_mid;
        if (push && cnt_mid != CW'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_mid) ent_n[i] = din;
            end
            cnt_n = cnt_mid + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count <= cnt_n;
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
        end
    end

    assign head_valid = (count != '0);
    assign head       = ent[0];

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: one outstanding fetch, 2-cycle min issue-to-visible, stalls issue while queue full.
// Define IF_PREFETCH_DROP_CNT_EN to add the saturating drop_cnt output.
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH    = IF_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
`ifdef IF_PREFETCH_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    input  logic        inst_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    if_state_e     state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;
    logic          space;
    logic          head_valid;
    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;

    assign push_ent = '{pc: fetch_pc, word: mem_rdata};
    assign pop      = head_valid && inst_ready;
    assign push     = (state == WAIT) && mem_ack && !redirect_valid;
    // A pop this cycle frees a slot, so a full queue can refill without an idle cycle.
    assign space    = (count != CW'(DEPTH)) || pop;

    if_fifo #(
        .DEPTH (DEPTH),
        .W     (64),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .din        (push_ent),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head_ent),
        .count      (count)
    );

    assign inst_valid = head_valid;
    assign inst_pc    = head_ent.pc;
    assign inst_data  = head_ent.word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= align_pc(redirect_pc);
                    end else if (space) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= align_pc(redirect_pc);
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state   <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        mem_req  <= 1'b0;
                        fetch_pc <= fetch_pc + FETCH_INC;
                        state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef IF_PREFETCH_DROP_CNT_EN
    logic drop;
    assign drop = mem_ack && (((state == WAIT) && redirect_valid) || (state == DISCARD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
